// File: rtl/add_seq_pkg.sv
// Shared types and constants for the nibble-serial adder: FSM state encoding
// and the width of one adder slice.
package add_seq_pkg;

    localparam int NIBW = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add_seq_if.sv
// Operand/result handshake bundle for add_seq; the operand source drives the
// master side, the adder implements the slave side.
interface add_seq_if
    import add_seq_pkg::*;
#(
    parameter int NIB = 4
);
    localparam int W = NIBW * NIB;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, out, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, out, cout
    );

endinterface

// File: rtl/add_seq_add_4.sv
// Combinational 4-bit ripple-carry adder built from explicit full-adder cells;
// the per-nibble datapath slice of add_seq.
module add_4
    import add_seq_pkg::*;
(
    input  logic [NIBW-1:0] a,
    input  logic [NIBW-1:0] b,
    input  logic            ci,
    output logic [NIBW-1:0] s,
    output logic            co
);

    logic [NIBW:0] c_s;

    // Ripple the carry through one full-adder cell per bit.
    always_comb begin
        c_s    = {(NIBW+1){1'b0}};
        s      = {NIBW{1'b0}};
        c_s[0] = ci;
        for (int i = 0; i < NIBW; i++) begin
            s[i]     = a[i] ^ b[i] ^ c_s[i];
            c_s[i+1] = (a[i] & b[i]) | (a[i] & c_s[i]) | (b[i] & c_s[i]);
        end
        co = c_s[NIBW];
    end

endmodule

// File: rtl/add_seq.sv
// Multi-cycle W-bit adder: latches operands on the input handshake, adds one
// nibble per clock through a single add_4, then holds the sum until consumed.
module add_seq
    import add_seq_pkg::*;
#(
    parameter int NIB = 4
)
(
    input  logic      clk,
    input  logic      rst,
    add_seq_if.slave  bus
);

    localparam int W  = NIBW * NIB;
    localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    result_q, result_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic [NIBW-1:0] a_nib_s;
    logic [NIBW-1:0] b_nib_s;
    logic [NIBW-1:0] sum_s;
    logic            co_s;

    // Select the operand nibbles addressed by the counter.
    always_comb begin
        a_nib_s = {NIBW{1'b0}};
        b_nib_s = {NIBW{1'b0}};
        for (int k = 0; k < NIB; k++) begin
            if (cnt_q == CW'(k)) begin
                a_nib_s = a_q[k*NIBW +: NIBW];
                b_nib_s = b_q[k*NIBW +: NIBW];
            end else begin
            end
        end
    end

    add_4 u_add (
        .a  (a_nib_s),
        .b  (b_nib_s),
        .ci (carry_q),
        .s  (sum_s),
        .co (co_s)
    );

    // FSM next state, operand capture and per-nibble result update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_RUN;
                end else begin
                end
            end
            ST_RUN: begin
                for (int k = 0; k < NIB; k++) begin
                    if (cnt_q == CW'(k)) begin
                        result_d[k*NIBW +: NIBW] = sum_s;
                    end else begin
                    end
                end
                carry_d = co_s;
                // Park the counter at zero instead of stepping past the top nibble.
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = {CW{1'b0}};
                    cout_d  = co_s;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
            end
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CW{1'b0}};
            a_q         <= {W{1'b0}};
            b_q         <= {W{1'b0}};
            result_q    <= {W{1'b0}};
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = result_q;
    assign bus.cout      = cout_q;

endmodule
